// File: rtl/hd_program_loader.sv
// Copies a program image from the track/sector disk into instruction memory, one word per
// sector, owning disk addressing and IM write strobes for the whole transfer.
module hd_program_loader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned HD_LAT = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] SrcTrilha,
  input  logic [DATA_W-1:0] SrcSetor,
  input  logic [DATA_W-1:0] NumWords,
  input  logic [DATA_W-1:0] DstAddr,
  output logic [DATA_W-1:0] HDTrilha,
  output logic [DATA_W-1:0] HDSetor,
  input  logic [DATA_W-1:0] HDData,
  output logic [DATA_W-1:0] IMAddr,
  output logic [DATA_W-1:0] IMData,
  output logic              IMWrite,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] WordsDone
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone} state_e;

  // Last WAIT count before data is valid; WAIT is never entered when HD_LAT is 1.
  localparam logic [2:0] WaitLast = 3'((HD_LAT > 1) ? HD_LAT - 2 : 0);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] trk_q, trk_d;
  logic [DATA_W-1:0] sec_q, sec_d;
  logic [DATA_W-1:0] num_q, num_d;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] words_q, words_d;
  logic [DATA_W-1:0] hd_trk_q, hd_trk_d;
  logic [DATA_W-1:0] hd_sec_q, hd_sec_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] idx_inc;

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    trk_d    = trk_q;
    sec_d    = sec_q;
    num_d    = num_q;
    dst_d    = dst_q;
    idx_d    = idx_q;
    words_d  = words_q;
    hd_trk_d = hd_trk_q;
    hd_sec_d = hd_sec_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          trk_d   = SrcTrilha;
          sec_d   = SrcSetor;
          num_d   = NumWords;
          dst_d   = DstAddr;
          idx_d   = '0;
          words_d = '0;
          if (NumWords == '0) begin
            state_d = StDone;
          end else begin
            // Address registers load here so they are valid during the READ cycle.
            hd_trk_d = SrcTrilha;
            hd_sec_d = SrcSetor;
            state_d  = StRead;
          end
        end
      end
      StRead: begin
        cnt_d   = '0;
        state_d = (HD_LAT <= 1) ? StWrite : StWait;
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StWrite: begin
        idx_d   = idx_inc;
        words_d = words_q + 1'b1;
        if (idx_inc == num_q) begin
          state_d = StDone;
        end else begin
          hd_sec_d = sec_q + idx_inc;
          state_d  = StRead;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= StIdle;
      trk_q    <= '0;
      sec_q    <= '0;
      num_q    <= '0;
      dst_q    <= '0;
      idx_q    <= '0;
      words_q  <= '0;
      hd_trk_q <= '0;
      hd_sec_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      trk_q    <= trk_d;
      sec_q    <= sec_d;
      num_q    <= num_d;
      dst_q    <= dst_d;
      idx_q    <= idx_d;
      words_q  <= words_d;
      hd_trk_q <= hd_trk_d;
      hd_sec_q <= hd_sec_d;
      cnt_q    <= cnt_d;
    end
  end

  assign HDTrilha  = hd_trk_q;
  assign HDSetor   = hd_sec_q;
  assign IMWrite   = (state_q == StWrite);
  assign IMData    = IMWrite ? HDData : '0;
  assign IMAddr    = dst_q + idx_q;
  assign Busy      = (state_q != StIdle);
  assign Done      = (state_q == StDone);
  assign WordsDone = words_q;

  // trk_q is kept so the track is part of the latched transfer context.
  logic unused_trk;
  assign unused_trk = ^trk_q;

endmodule

// File: doc/hd_program_loader.md
Name: hd_program_loader

Overview:
- Sequencer that copies a program image from the hard-disk block (track/sector addressed, synchronous read) into instruction memory, one word per sector.
- Sits between the OS-level control (load request raised on a loader instruction) and the disk/instruction-memory ports.
- Owns disk addressing and instruction-memory write strobes for the whole transfer, so the datapath only issues a start and waits for done.

Parameters:
- DATA_W, 32, width of disk words, instruction words, addresses and counts.
- HD_LAT, 1, disk read latency in clock cycles from address valid to data valid; legal range 1..4.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  transfer request; sampled only in IDLE.
- SrcTrilha  in  DATA_W  source track number.
- SrcSetor  in  DATA_W  first source sector.
- NumWords  in  DATA_W  number of words to copy.
- DstAddr  in  DATA_W  first instruction-memory address (word index).
- HDTrilha  out  DATA_W  track address to disk.
- HDSetor  out  DATA_W  sector address to disk.
- HDData  in  DATA_W  disk read data, valid HD_LAT cycles after address.
- IMAddr  out  DATA_W  instruction-memory write address.
- IMData  out  DATA_W  instruction-memory write data.
- IMWrite  out  1  instruction-memory write enable, one cycle per word.
- Busy  out  1  high from the cycle after an accepted Start until DONE is left.
- Done  out  1  one-cycle completion pulse.
- WordsDone  out  DATA_W  words written in the current or last transfer.

Behaviour:
- Clock and reset: single clock CLK. Reset is synchronous and active-high.
- Reset values: state IDLE; all outputs 0 (HDTrilha, HDSetor, IMAddr, IMData, IMWrite, Busy, Done, WordsDone).
- Reset mid-transfer: at the next edge go to IDLE with IMWrite=0. No further writes. WordsDone clears to 0.
- Start acceptance:
  - In IDLE with Start=1, latch SrcTrilha, SrcSetor, NumWords and DstAddr into internal registers, and clear WordsDone.
  - Inputs are don't-care after acceptance.
  - Start is ignored in every state except IDLE; no queuing.
- States:
  - IDLE: Busy=0. On Start, go to DONE if NumWords==0, else go to READ.
  - READ: drive HDTrilha=trk, HDSetor=sec+i (modulo 2^DATA_W wrap). Go to WAIT.
  - WAIT: hold the address. Count HD_LAT cycles in total from READ's address (HD_LAT-1 cycles spent in WAIT), then go to WRITE. With HD_LAT=1, WAIT is skipped (READ goes straight to WRITE).
  - WRITE: IMWrite=1 for exactly one cycle, IMAddr=dst+i, IMData=HDData. Increment i and WordsDone. If i+1==NumWords go to DONE, else go to READ.
  - DONE: Done=1 for one cycle, Busy still 1. Go to IDLE.
- Timing: throughput is one word per (HD_LAT+1) cycles. Total latency from accepted Start to the Done pulse is NumWords*(HD_LAT+1)+1 cycles.
- HDTrilha/HDSetor hold their last driven value outside READ/WAIT.
- IMWrite is never high outside WRITE. Done and IMWrite are never high together.
- Address arithmetic: wraps modulo 2^DATA_W with no error flag. Counter i is DATA_W bits wide, so NumWords=2^DATA_W-1 is legal.
- WordsDone: holds its final value in IDLE until the next accepted Start or Reset.

Test Plan:
- Reset, then NumWords=3, SrcTrilha=2, SrcSetor=5, DstAddr=0x10, HD_LAT=1, disk holding 0xA,0xB,0xC at sectors 5..7 -> IMWrite pulses at cycles 2,4,6 after Start with (0x10,0xA),(0x11,0xB),(0x12,0xC); Done at cycle 7; WordsDone=3.
- Start with NumWords=0 -> no IMWrite, Busy high one cycle, Done pulse the cycle after acceptance, WordsDone=0.
- HD_LAT=3, NumWords=2 -> HDSetor held 3 cycles per word, IMWrite every 4 cycles, data matches the sector contents.
- Start re-asserted with different inputs while Busy -> ignored; original transfer completes unchanged.
- Reset asserted after the 2nd IMWrite of a 5-word transfer -> IMWrite low from the next edge, state IDLE, WordsDone=0, and a new Start is accepted normally.
- SrcSetor=0xFFFFFFFF, DstAddr=0xFFFFFFFF, NumWords=2 -> second access uses sector 0 and IMAddr 0 (wrap).
